// File: rtl/stl_arb_pkg.sv
// rtl/stl_arb_pkg.sv - shared types and helpers for the round-robin lock arbiter
//
// Purpose: arbiter state encoding and the thermometer mask used for
//          rotating-priority selection.
// Contents:
//   arb_state_e - ARB_IDLE (no owner) / ARB_LOCKED (owner holds resource)
//   ARB_MAX_N   - widest requester vector ge_mask can describe
//   ge_mask     - returns a mask with bits ptr..n-1 set

package stl_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  localparam int ARB_MAX_N = 32;

  function automatic logic [ARB_MAX_N-1:0] ge_mask(input int ptr, input int n);
    logic [ARB_MAX_N-1:0] m;
    m = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (i >= ptr && i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/StlTzc.sv
// rtl/StlTzc.sv - trailing-zero counter, position of the lowest set bit
//
// Purpose: returns the index of the least-significant '1' in vec_i.
//          The vector is padded up to 2**CW bits with ones, so the result
//          for an all-zero input is not meaningful; callers must qualify it
//          with their own OR-reduction.
// Ports:
//   vec_i     [DW-1:0]  input vector
//   pos_from0 [CW-1:0]  index of lowest set bit, counted from bit 0

module StlTzc #(
  parameter int DW = 4,
  parameter int CW = 2
) (
  input  logic [DW-1:0] vec_i,
  output logic [CW-1:0] pos_from0
);

  localparam int PW = 1 << CW;

  logic [PW-1:0] w_padded;

  always_comb begin
    w_padded          = '1;
    w_padded[DW-1:0]  = vec_i;
  end

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    pos_from0 = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (w_padded[i]) pos_from0 = CW'(i);
    end
  end

endmodule

// File: rtl/stl_rr_lock_arbiter.sv
// rtl/stl_rr_lock_arbiter.sv - round-robin arbiter that locks a shared resource per transaction
//
// Purpose: grants one of N requesters a shared single-port resource and
//          holds the grant until the owner's last beat is accepted. Priority
//          rotates to the requester after the finishing owner; handover to a
//          waiting requester happens in the same cycle as the last beat.
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   req_valid_i  [N]   per-requester beat valid
//   req_last_i   [N]   per-requester last-beat flag (meaningful with valid)
//   res_ready_i        resource accepts the owner's beat this cycle
//   gnt_o        [N]   one-hot grant, zero when idle
//   gnt_idx_o    [IW]  owner index, zero when idle
//   gnt_valid_o        a transaction is locked
//   beat_o             owner beat accepted this cycle (combinational)

module stl_rr_lock_arbiter
  import stl_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_valid_i,
  input  logic [N-1:0]  req_last_i,
  input  logic          res_ready_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o,
  output logic          beat_o
);

  arb_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [IW-1:0] r_ptr,   w_ptr_nxt;

  logic          w_locked;
  logic [N-1:0]  w_owner_oh;
  logic          w_last_xfer;
  logic [IW-1:0] w_ptr_after;
  logic [N-1:0]  w_cand;
  logic [IW-1:0] w_sel_ptr;
  logic [N-1:0]  w_ge;
  logic [N-1:0]  w_hi;
  logic [IW-1:0] w_idx_hi;
  logic [IW-1:0] w_idx_all;
  logic [IW-1:0] w_winner;
  logic          w_found;

  assign w_locked    = (r_state == ARB_LOCKED);
  assign w_owner_oh  = N'(1) << r_owner;
  assign beat_o      = req_valid_i[r_owner] & res_ready_i & w_locked;
  assign w_last_xfer = beat_o & req_last_i[r_owner];
  assign w_ptr_after = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

  // One selector serves both cases: fresh arbitration from IDLE, and
  // same-cycle handover on a last beat, where the finishing owner is
  // excluded and priority starts just past it.
  assign w_cand    = w_locked ? (req_valid_i & ~w_owner_oh) : req_valid_i;
  assign w_sel_ptr = w_locked ? w_ptr_after : r_ptr;
  assign w_ge      = N'(ge_mask(32'(w_sel_ptr), N));
  assign w_hi      = w_cand & w_ge;

  StlTzc #(.DW(N), .CW(IW)) u_tzc_hi (
    .vec_i     (w_hi),
    .pos_from0 (w_idx_hi)
  );

  StlTzc #(.DW(N), .CW(IW)) u_tzc_all (
    .vec_i     (w_cand),
    .pos_from0 (w_idx_all)
  );

  // Found comes from the candidate vector itself; the counters are
  // undefined for a zero input.
  assign w_found  = |w_cand;
  assign w_winner = (|w_hi) ? w_idx_hi : w_idx_all;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_nxt = ARB_LOCKED;
          w_owner_nxt = w_winner;
        end
      end
      ARB_LOCKED: begin
        if (w_last_xfer) begin
          w_ptr_nxt = w_ptr_after;
          if (w_found) begin
            w_owner_nxt = w_winner;
          end else begin
            w_state_nxt = ARB_IDLE;
            w_owner_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_owner_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt_valid_o = w_locked;
  assign gnt_o       = w_locked ? w_owner_oh : '0;
  assign gnt_idx_o   = w_locked ? r_owner : '0;

endmodule

// File: tb/tb_stl_rr_lock_arbiter.sv
// tb/tb_stl_rr_lock_arbiter.sv - directed vector bench for stl_rr_lock_arbiter

module tb_stl_rr_lock_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid_i;
  logic [N-1:0]  req_last_i;
  logic          res_ready_i;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          gnt_valid_o;
  logic          beat_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stl_rr_lock_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .res_ready_i (res_ready_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .beat_o      (beat_o)
  );

  typedef struct packed {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic          rdy;
    logic          chk_beat;
    logic          beat;
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          vld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N-1:0] q, input logic [N-1:0] l,
                     input logic y, input logic cb, input logic b,
                     input logic [N-1:0] g, input logic [IW-1:0] ix, input logic v);
    vec_t t;
    t.rst = r; t.req = q; t.last = l; t.rdy = y; t.chk_beat = cb; t.beat = b;
    t.gnt = g; t.idx = ix; t.vld = v;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid_i = '0; req_last_i = '0; res_ready_i = 1'b0;

    //   rst req      last     rdy cb beat gnt      idx vld
    // reset with all requesting
    add(1, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 0, 0);
    // release: owner 0 next cycle
    add(0, 4'b1111, 4'b1111, 0, 1, 0, 4'b0001, 0, 1);
    // back-to-back single beats rotate 1,2,3,0,1
    add(0, 4'b1111, 4'b1111, 1, 1, 1, 4'b0010, 1, 1);
    add(0, 4'b1111, 4'b1111, 1, 1, 1, 4'b0100, 2, 1);
    add(0, 4'b1111, 4'b1111, 1, 1, 1, 4'b1000, 3, 1);
    add(0, 4'b1111, 4'b1111, 1, 1, 1, 4'b0001, 0, 1);
    add(0, 4'b1111, 4'b1111, 1, 1, 1, 4'b0010, 1, 1);
    // reset, then multi-beat lock on owner 0 with req 2 waiting
    add(1, 4'b1111, 4'b1111, 1, 1, 1, 4'b0000, 0, 0);
    add(0, 4'b0101, 4'b0000, 0, 1, 0, 4'b0001, 0, 1);
    add(0, 4'b0101, 4'b0000, 1, 1, 1, 4'b0001, 0, 1);
    add(0, 4'b0101, 4'b0000, 0, 1, 0, 4'b0001, 0, 1);
    add(0, 4'b0101, 4'b0000, 1, 1, 1, 4'b0001, 0, 1);
    add(0, 4'b0101, 4'b0001, 1, 1, 1, 4'b0100, 2, 1);
    // owner 2 finishes, ptr wraps past 3 to 0 ahead of 1
    add(0, 4'b0111, 4'b0100, 1, 1, 1, 4'b0001, 0, 1);
    add(0, 4'b0011, 4'b0001, 1, 1, 1, 4'b0010, 1, 1);
    // sole requester 1: bubble through IDLE between transactions
    add(0, 4'b0010, 4'b0010, 1, 1, 1, 4'b0000, 0, 0);
    add(0, 4'b0010, 4'b0010, 1, 1, 0, 4'b0010, 1, 1);
    add(0, 4'b0010, 4'b0010, 1, 1, 1, 4'b0000, 0, 0);
    add(0, 4'b0010, 4'b0010, 1, 1, 0, 4'b0010, 1, 1);
    // hand over to 2, then reset mid-transaction coinciding with a last beat
    add(0, 4'b0110, 4'b0010, 1, 1, 1, 4'b0100, 2, 1);
    add(0, 4'b0100, 4'b0000, 1, 1, 1, 4'b0100, 2, 1);
    add(1, 4'b0100, 4'b0100, 1, 1, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 1, 0, 4'b0001, 0, 1);
    // owner drops valid: lock held, others ignored
    add(0, 4'b1110, 4'b1111, 1, 1, 0, 4'b0001, 0, 1);
    add(0, 4'b1111, 4'b0000, 1, 1, 1, 4'b0001, 0, 1);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; req_valid_i = vecs[i].req;
      req_last_i = vecs[i].last; res_ready_i = vecs[i].rdy;
      #1;
      if (vecs[i].chk_beat) chk("beat", i, 32'(beat_o), 32'(vecs[i].beat));
      @(posedge clk); #1;
      chk("gnt", i, 32'(gnt_o), 32'(vecs[i].gnt));
      chk("idx", i, 32'(gnt_idx_o), 32'(vecs[i].idx));
      chk("vld", i, 32'(gnt_valid_o), 32'(vecs[i].vld));
    end

    // Lone top requester: one-cycle grant latency after reset
    rst = 1'b1; req_valid_i = '0; req_last_i = '0; res_ready_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; req_valid_i = 4'b1000;
    n = 0;
    while (!gnt_valid_o && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat3", 0, 32'(n), 32'd1);
    chk("lat3_gnt", 0, 32'(gnt_o), 32'(4'b1000));
    chk("lat3_idx", 0, 32'(gnt_idx_o), 32'd3);

    // Its last beat with nobody waiting returns to IDLE
    req_last_i = 4'b1000; res_ready_i = 1'b1;
    #1;
    chk("last3_beat", 0, 32'(beat_o), 32'd1);
    @(posedge clk); #1;
    chk("last3_vld", 0, 32'(gnt_valid_o), 32'd0);

    // No requests: remain idle, ready ignored
    req_valid_i = '0; req_last_i = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle_vld", k, 32'(gnt_valid_o), 32'd0);
      chk("idle_beat", k, 32'(beat_o), 32'd0);
      chk("idle_gnt", k, 32'(gnt_o), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
